// File: rtl/lsu_pkg.sv
// Shared types and helpers for the multi-cycle load/store unit (lsu_mc).
// Optional build macro: LSU_MISALIGN_SPLIT_EN adds the ISSUE2/WAIT2 states.
// With it, word-crossing accesses are split into two word accesses.
package lsu_pkg;

  localparam int LSU_XLEN = 32;
  localparam int LSU_AW   = 14;

  // RV32I funct3 size/sign encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    RESP   = 3'd3
`ifdef LSU_MISALIGN_SPLIT_EN
    ,
    ISSUE2 = 3'd4,
    WAIT2  = 3'd5
`endif
  } lsu_state_t;

  typedef struct packed {
    logic                store;
    logic [2:0]          funct3;
    logic [LSU_AW-1:0]   addr;
    logic [LSU_XLEN-1:0] wdata;
  } lsu_req_t;

  // Stores only exist in the signed-size encodings; BU/HU are load-only.
  function automatic logic f3_legal(input logic store, input logic [2:0] funct3);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // size is funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

`ifdef LSU_MISALIGN_SPLIT_EN
  // True when the access spills into the next memory word.
  function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] off);
    logic cross;
    case (size)
      2'b01:   cross = (off == 2'b11);
      2'b10:   cross = (off != 2'b00);
      default: cross = 1'b0;
    endcase
    return cross;
  endfunction
`endif

endpackage

// File: rtl/lsu_mc_if.sv
// Core-request / memory-port bundle for lsu_mc.
// slave is the LSU side; master is the core+memory environment side.
interface lsu_mc_if #(
  parameter int XLEN = lsu_pkg::LSU_XLEN,
  parameter int AW   = lsu_pkg::LSU_AW
);
  logic            req_valid;
  logic            req_ready;
  logic            req_store;
  logic [2:0]      req_funct3;
  logic [AW-1:0]   req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_fault;
  logic            mem_req;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [AW-3:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for lsu_mc: byte enables, store-data lane
// placement and load extraction/extension. With LSU_MISALIGN_SPLIT_EN the
// upper-word half of a crossing access is produced as well.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]          funct3,
  input  logic [1:0]          off,
  input  logic [LSU_XLEN-1:0] wdata,
  input  logic [LSU_XLEN-1:0] rdata_lo,
`ifdef LSU_MISALIGN_SPLIT_EN
  input  logic [LSU_XLEN-1:0] rdata_hi,
  output logic [3:0]          be_hi,
  output logic [LSU_XLEN-1:0] wdata_hi,
`endif
  output logic [3:0]          be_lo,
  output logic [LSU_XLEN-1:0] wdata_lo,
  output logic [LSU_XLEN-1:0] rdata_ext
);

  logic [3:0]          mask_s;
  logic [LSU_XLEN-1:0] rep_s;
  logic [LSU_XLEN-1:0] sh_lo_s;
  logic [LSU_XLEN-1:0] rd_sh_s;
  logic [4:0]          bit_off_s;

  assign bit_off_s = {off, 3'b000};

  // Unshifted byte-enable mask for the access size
  always_comb begin
    case (funct3[1:0])
      2'b00:   mask_s = 4'b0001;
      2'b01:   mask_s = 4'b0011;
      2'b10:   mask_s = 4'b1111;
      default: mask_s = 4'b0000;
    endcase
  end

  // Replicated store data: every lane already holds the right bytes
  always_comb begin
    case (funct3[1:0])
      2'b00:   rep_s = {4{wdata[7:0]}};
      2'b01:   rep_s = {2{wdata[15:0]}};
      default: rep_s = wdata;
    endcase
  end

  assign be_lo   = mask_s << off;
  assign sh_lo_s = wdata << bit_off_s;
  // Aligned accesses use replication; shifted placement only when lanes move across the natural boundary
  assign wdata_lo = is_misaligned(funct3[1:0], off) ? sh_lo_s : rep_s;

`ifdef LSU_MISALIGN_SPLIT_EN
  assign be_hi    = 4'(({4'b0000, mask_s} << off) >> 3'd4);
  assign wdata_hi = 32'(({32'h0000_0000, wdata} << bit_off_s) >> 6'd32);
  assign rd_sh_s  = 32'({rdata_hi, rdata_lo} >> bit_off_s);
`else
  assign rd_sh_s  = rdata_lo >> bit_off_s;
`endif

  // Load extraction: pick low 8/16/32 bits and sign- or zero-extend
  always_comb begin
    case (funct3)
      F3_B:    rdata_ext = {{24{rd_sh_s[7]}}, rd_sh_s[7:0]};
      F3_BU:   rdata_ext = {24'h00_0000, rd_sh_s[7:0]};
      F3_H:    rdata_ext = {{16{rd_sh_s[15]}}, rd_sh_s[15:0]};
      F3_HU:   rdata_ext = {16'h0000, rd_sh_s[15:0]};
      F3_W:    rdata_ext = rd_sh_s;
      default: rdata_ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: core valid/ready request in, byte-enabled
// word access on a req/gnt/rvalid memory port, one-cycle response out.
// Optional build macro: LSU_MISALIGN_SPLIT_EN (split word-crossing accesses).
module lsu_mc
  import lsu_pkg::*;
#(
  parameter int XLEN = LSU_XLEN,
  parameter int AW   = LSU_AW
) (
  input logic     clk,
  input logic     reset,
  lsu_mc_if.slave bus
);

  localparam int WAW = AW - 2;

  lsu_state_t      state_q, state_d;
  lsu_req_t        req_q, req_d, cur_s;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_fault_q, rsp_fault_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [WAW-1:0]  mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

  logic            fault_s;
  logic [3:0]      be_lo_s;
  logic [XLEN-1:0] wdata_lo_s, rdata_lo_s, rdata_ext_s;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic            split_q, split_d, split_s;
  logic [XLEN-1:0] lo_word_q, lo_word_d;
  logic [3:0]      be_hi_s;
  logic [XLEN-1:0] wdata_hi_s;
`endif

  // Request view: live core inputs while idle, latched copy once accepted
  always_comb begin
    cur_s = req_q;
    if (state_q == IDLE) begin
      cur_s.store  = bus.req_store;
      cur_s.funct3 = bus.req_funct3;
      cur_s.addr   = bus.req_addr;
      cur_s.wdata  = bus.req_wdata;
    end else begin
      cur_s = req_q;
    end
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  assign split_s    = crosses_word(cur_s.funct3[1:0], cur_s.addr[1:0]);
  assign fault_s    = ~f3_legal(cur_s.store, cur_s.funct3);
  assign rdata_lo_s = (state_q == WAIT2) ? lo_word_q : bus.mem_rdata;
`else
  assign fault_s    = ~f3_legal(cur_s.store, cur_s.funct3) |
                      is_misaligned(cur_s.funct3[1:0], cur_s.addr[1:0]);
  assign rdata_lo_s = bus.mem_rdata;
`endif

  lsu_align u_align (
    .funct3    (cur_s.funct3),
    .off       (cur_s.addr[1:0]),
    .wdata     (cur_s.wdata),
    .rdata_lo  (rdata_lo_s),
`ifdef LSU_MISALIGN_SPLIT_EN
    .rdata_hi  (bus.mem_rdata),
    .be_hi     (be_hi_s),
    .wdata_hi  (wdata_hi_s),
`endif
    .be_lo     (be_lo_s),
    .wdata_lo  (wdata_lo_s),
    .rdata_ext (rdata_ext_s)
  );

  // Next-state and next-output logic; every output is a flop
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_fault_d = rsp_fault_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    split_d     = split_q;
    lo_word_d   = lo_word_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d       = cur_s;
          req_ready_d = 1'b0;
          rsp_rdata_d = '0;
          if (fault_s) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
          end else begin
            state_d     = ISSUE;
            rsp_fault_d = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = cur_s.store;
            mem_be_d    = be_lo_s;
            mem_addr_d  = cur_s.addr[AW-1:2];
            mem_wdata_d = wdata_lo_s;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_d     = split_s;
`endif
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ISSUE: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = WAIT;
        end else begin
          state_d   = ISSUE;
        end
      end
      WAIT: begin
        if (!bus.mem_rvalid) begin
          state_d = WAIT;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        else if (split_q) begin
          lo_word_d   = bus.mem_rdata;
          state_d     = ISSUE2;
          mem_req_d   = 1'b1;
          mem_be_d    = be_hi_s;
          mem_wdata_d = wdata_hi_s;
          mem_addr_d  = mem_addr_q + {{(WAW-1){1'b0}}, 1'b1};
        end
`endif
        else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = req_q.store ? '0 : rdata_ext_s;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ISSUE2: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = WAIT2;
        end else begin
          state_d   = ISSUE2;
        end
      end
      WAIT2: begin
        if (bus.mem_rvalid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = req_q.store ? '0 : rdata_ext_s;
        end else begin
          state_d     = WAIT2;
        end
      end
`endif
      RESP: begin
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        mem_req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q     <= 1'b0;
      lo_word_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q     <= split_d;
      lo_word_q   <= lo_word_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
